// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the four-channel round-robin stream mux.
package rr_mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first request at or after start (mod 4),
// ignoring channels in the exclude mask.
module rr_pick4
  import rr_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  start,
  input  logic [NUM_CH-1:0] exclude,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [NUM_CH-1:0] cand;
  logic [SEL_W-1:0]  ch;

  // NOTE: every variable written in always_comb gets a default before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    cand  = req & ~exclude;
    found = 1'b0;
    idx   = start;
    ch    = start;
    // Scan from the farthest offset down so the nearest hit is written last.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      ch = start + SEL_W'(i);
      if (cand[ch]) begin
        found = 1'b1;
        idx   = ch;
      end
    end
  end

endmodule

// File: rtl/rr_mux4.sv
// Four-channel round-robin valid/ready merger with burst-limited fairness and a
// single registered output stage tagged with the source channel.
module rr_mux4
  import rr_mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  owner, owner_nxt;
  logic [SEL_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0]  burst_cnt, burst_nxt;

  logic              can_load;
  logic              owner_keep;
  logic              pick_found;
  logic              xfer;
  logic [SEL_W-1:0]  pick_idx;
  logic [SEL_W-1:0]  winner;
  logic [NUM_CH-1:0] excl;

  assign can_load   = !out_valid || out_ready;
  assign owner_keep = (state == GRANT) && in_valid[owner] && (burst_cnt < BURST_MAX);
  assign excl       = (state == GRANT && burst_cnt == BURST_MAX) ? ch_onehot(owner) : '0;

  rr_pick4 u_pick (
    .req     (in_valid),
    .start   (ptr),
    .exclude (excl),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // An exhausted owner that is the only requester falls through the exclusion
  // and keeps the grant.
  assign winner   = (owner_keep || !pick_found) ? owner : pick_idx;
  assign in_ready = (rst_n && can_load && |in_valid) ? ch_onehot(winner) : '0;
  assign xfer     = |in_ready;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = GRANT;
          owner_nxt = winner;
          burst_nxt = CNT_ONE;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (winner == owner) begin
            burst_nxt = (burst_cnt == BURST_MAX) ? CNT_ONE : burst_cnt + CNT_ONE;
          end else begin
            owner_nxt = winner;
            burst_nxt = CNT_ONE;
            ptr_nxt   = owner + SEL_W'(1);
          end
        end else if (can_load) begin
          state_nxt = IDLE;
          ptr_nxt   = owner + SEL_W'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (can_load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[winner*WIDTH +: WIDTH];
        out_sel  <= winner;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux4.sv
// Directed table-driven bench for rr_mux4 (WIDTH=8, MAX_BURST=4).
module tb_rr_mux4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  rr_mux4 #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  ir;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  sel;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] D   = {8'h73, 8'h5A, 8'h21, 8'h10};
  localparam logic [31:0] DA1 = {8'hA1, 8'h5A, 8'h21, 8'h10};
  localparam logic [31:0] DA2 = {8'hA2, 8'h5A, 8'h21, 8'h10};

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] iv, input logic [31:0] d, input logic ordy,
                              input logic [3:0] ir, input logic ov, input logic [7:0] od,
                              input logic [1:0] sel);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.ir = ir; v.ov = ov; v.od = od; v.sel = sel;
    return v;
  endfunction

  // Called just after a rising edge: drive, check in_ready mid-cycle, then check
  // the registered outputs just after the next edge.
  task automatic step(input string name, input int idx, input vec_t v);
    in_valid  = v.iv;
    in_data   = v.d;
    out_ready = v.ordy;
    #2;
    check({name, ".in_ready"}, idx, {28'd0, in_ready}, {28'd0, v.ir});
    @(posedge clk);
    #1;
    check({name, ".out_valid"}, idx, {31'd0, out_valid}, {31'd0, v.ov});
    check({name, ".out_data"}, idx, {24'd0, out_data}, {24'd0, v.od});
    check({name, ".out_sel"}, idx, {30'd0, out_sel}, {30'd0, v.sel});
  endtask

  initial begin
    logic [7:0] ch_byte [4];
    ch_byte = '{8'h10, 8'h21, 8'h5A, 8'h73};

    // All channels busy: bursts of four, rotating 0,1,2,3 then back to 0.
    for (int i = 0; i < 17; i++) begin
      int ch;
      ch = (i / 4) % 4;
      tbl.push_back(mk(4'b1111, D, 1'b1, 4'(1 << ch), 1'b1, ch_byte[ch], 2'(ch)));
    end
    // Single ch2 beat, then idle (ptr -> 3).
    tbl.push_back(mk(4'b0100, D, 1'b1, 4'b0100, 1'b1, 8'h5A, 2'd2));
    tbl.push_back(mk(4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd2));
    // Channel 3 alone for 10 beats across burst rollovers, then idle (ptr wraps to 0).
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(4'b1000, D, 1'b1, 4'b1000, 1'b1, 8'h73, 2'd3));
    tbl.push_back(mk(4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h73, 2'd3));
    // Wrapped ptr=0 picks ch1 ahead of ch3; idle moves ptr to 2.
    tbl.push_back(mk(4'b1010, D, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1));
    tbl.push_back(mk(4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h21, 2'd1));
    // Stall: ch3 beat A1 accepted, next beat A2 waits 3 stalled cycles, then loads.
    tbl.push_back(mk(4'b1010, DA1, 1'b1, 4'b1000, 1'b1, 8'hA1, 2'd3));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(4'b1010, DA2, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd3));
    tbl.push_back(mk(4'b1010, DA2, 1'b1, 4'b1000, 1'b1, 8'hA2, 2'd3));
    tbl.push_back(mk(4'b0000, DA2, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd3));
    // Empty output register loads even with out_ready low, then stalls.
    tbl.push_back(mk(4'b0001, D, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0));
    tbl.push_back(mk(4'b0001, D, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0));
    tbl.push_back(mk(4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0));
    // ptr=1: ch2 wins, then idle moves ptr to 3.
    tbl.push_back(mk(4'b0100, D, 1'b1, 4'b0100, 1'b1, 8'h5A, 2'd2));
    tbl.push_back(mk(4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h5A, 2'd2));

    // Reset, with inputs valid to show in_ready stays low.
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = D;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      check("rst.in_ready", i, {28'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("rst.outs", i, {22'd0, out_valid, out_data, out_sel}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      step("idle", i, mk(4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0));

    foreach (tbl[i]) step("tbl", i, tbl[i]);

    // Channel 1 burst from ptr=3, reset mid-burst, then first grant from ptr=0.
    step("burst1", 0, mk(4'b0010, 32'h0000_3100, 1'b1, 4'b0010, 1'b1, 8'h31, 2'd1));
    step("burst1", 1, mk(4'b0010, 32'h0000_3200, 1'b1, 4'b0010, 1'b1, 8'h32, 2'd1));
    rst_n = 1'b0;
    step("rst_mid", 0, mk(4'b0010, 32'h0000_3300, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0));
    rst_n = 1'b1;
    step("post_rst", 0, mk(4'b1010, 32'h8800_4400, 1'b1, 4'b0010, 1'b1, 8'h44, 2'd1));
    step("post_rst", 1, mk(4'b0000, 32'h8800_4400, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
